// File: rtl/xgmii_32to64.sv
// ---------------------------------------------------------------------------
// xgmii_32to64 -- TX-path width gearbox, 32-bit XGMII beats to 64-bit words.
//
// Each consecutive pair of accepted 32-bit beats is packed into one 64-bit
// word for the 64b/66b encoder. The first beat of a pair becomes lanes 0-3
// and the second beat becomes lanes 4-7. Start characters outside lane 0 of
// a beat are flagged, but the data is never modified.
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   synchronous reset, active low
//   xgmii_in   in   37  32-bit XGMII beat, ena = beat valid
//   sync_clr   in   1   force packing phase to LOW, drop any held half
//   xgmii_out  out  73  packed 64-bit word, ena = one-cycle word strobe
//   phase      out  1   0 = no half held, 1 = lower half held
//   lane_err   out  1   one-cycle pulse on an illegal Start placement
// ---------------------------------------------------------------------------

package gtype;

  typedef struct packed {
    logic        ena;
    logic [3:0]  ctrl;
    logic [31:0] data;
  } xgmii32_t;

  typedef struct packed {
    logic        ena;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii64_t;

endpackage

module xgmii_32to64
  import gtype::*;
#(
  parameter logic [7:0] IDLE_CHAR  = 8'h07,
  parameter logic [7:0] START_CHAR = 8'hFB
) (
  input  logic     clk,
  input  logic     rst_n,
  input  xgmii32_t xgmii_in,
  input  logic     sync_clr,
  output xgmii64_t xgmii_out,
  output logic     phase,
  output logic     lane_err
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  localparam logic [31:0] IDLE_HALF = {4{IDLE_CHAR}};

  phase_e      r_state;
  phase_e      w_nextState;
  logic [3:0]  r_holdCtrl;
  logic [31:0] r_holdData;
  xgmii64_t    r_out;
  logic        r_laneErr;

  logic        w_accept;
  logic        w_storeLow;
  logic        w_packWord;
  logic [3:0]  w_isStart;
  logic        w_startErr;

  // Accept qualification and the decisions derived from it. A sync_clr that
  // arrives with a beat restarts the pairing, so that beat is always stored
  // as a fresh lower half and never completes an older one.
  always_comb begin
    w_accept   = xgmii_in.ena;
    w_storeLow = w_accept && ((r_state == PH_LOW) || sync_clr);
    w_packWord = w_accept && (r_state == PH_HIGH) && !sync_clr;
  end

  // Start detection per lane; only lane 0 may legally carry a Start.
  always_comb begin
    w_isStart = '0;
    for (int i = 0; i < 4; i++) begin
      w_isStart[i] = xgmii_in.ctrl[i] && (xgmii_in.data[8*i +: 8] == START_CHAR);
    end
    w_startErr = w_accept && (|w_isStart[3:1]);
  end

  // Next-state logic for the packing phase.
  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      w_nextState = w_storeLow ? PH_HIGH : PH_LOW;
    end else if (sync_clr) begin
      w_nextState = PH_LOW;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= PH_LOW;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Holding register for the lower half. A sync_clr without a beat wipes it
  // back to idle so a dropped half can never leak into a later word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_holdCtrl <= 4'hF;
      r_holdData <= IDLE_HALF;
    end else if (w_storeLow) begin
      r_holdCtrl <= xgmii_in.ctrl;
      r_holdData <= xgmii_in.data;
    end else if (sync_clr) begin
      r_holdCtrl <= 4'hF;
      r_holdData <= IDLE_HALF;
    end
  end

  // Output word register. ctrl/data only change when a word is completed, so
  // they keep their last value while the strobe is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out.ena  <= 1'b0;
      r_out.ctrl <= 8'hFF;
      r_out.data <= {2{IDLE_HALF}};
    end else begin
      r_out.ena <= w_packWord;
      if (w_packWord) begin
        r_out.ctrl <= {xgmii_in.ctrl, r_holdCtrl};
        r_out.data <= {xgmii_in.data, r_holdData};
      end
    end
  end

  // Lane error pulse, independent of sync_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_laneErr <= 1'b0;
    end else begin
      r_laneErr <= w_startErr;
    end
  end

  assign xgmii_out = r_out;
  assign phase     = (r_state == PH_HIGH);
  assign lane_err  = r_laneErr;

endmodule

// File: tb/tb_xgmii_32to64.sv
// ---------------------------------------------------------------------------
// tb_xgmii_32to64 -- scoreboard bench for the 32-to-64 XGMII gearbox.
//
// The stimulus process pushes each expected 64-bit word when it issues the
// beat that completes it; the monitor pops and compares on every strobe.
// ---------------------------------------------------------------------------

module tb_xgmii_32to64;
  import gtype::*;

  logic     clk;
  logic     rst_n;
  xgmii32_t xgmii_in;
  logic     sync_clr;
  xgmii64_t xgmii_out;
  logic     phase;
  logic     lane_err;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  word_t expQ[$];
  int    totalCount = 0;
  int    passCount  = 0;

  xgmii_32to64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xgmii_in  (xgmii_in),
    .sync_clr  (sync_clr),
    .xgmii_out (xgmii_out),
    .phase     (phase),
    .lane_err  (lane_err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by stimulus and monitor.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge and return at the next negedge,
  // by which time the DUT has registered the effect of this cycle.
  task automatic applyStimulus(input logic ena, input logic [3:0] ctrl,
                               input logic [31:0] data, input logic sclr);
    xgmii_in.ena  = ena;
    xgmii_in.ctrl = ctrl;
    xgmii_in.data = data;
    sync_clr      = sclr;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic expectWord(input logic [7:0] ctrl, input logic [63:0] data);
    word_t w;
    w.ctrl = ctrl;
    w.data = data;
    expQ.push_back(w);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && xgmii_out.ena) begin
      if (expQ.size() == 0) begin
        totalCount++;
        $display("[TB] FAIL unexpected_strobe: got ctrl=%h data=%h, expected no strobe",
                 xgmii_out.ctrl, xgmii_out.data);
      end else begin
        word_t w;
        w = expQ.pop_front();
        checkOutput("word_ctrl", {56'h0, xgmii_out.ctrl}, {56'h0, w.ctrl});
        checkOutput("word_data", xgmii_out.data, w.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    xgmii_in = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ena",   {63'h0, xgmii_out.ena},  64'h0);
    checkOutput("reset_ctrl",  {56'h0, xgmii_out.ctrl}, 64'hFF);
    checkOutput("reset_data",  xgmii_out.data,          64'h0707070707070707);
    checkOutput("reset_phase", {63'h0, phase},          64'h0);
    checkOutput("reset_lerr",  {63'h0, lane_err},       64'h0);
    rst_n = 1'b1;
    idleCycle();

    // Idle stream: phase toggles 1,0,1,0 and two idle words emerge.
    applyStimulus(1'b1, 4'hF, 32'h07070707, 1'b0);
    checkOutput("idle_phase1", {63'h0, phase}, 64'h1);
    expectWord(8'hFF, 64'h0707070707070707);
    applyStimulus(1'b1, 4'hF, 32'h07070707, 1'b0);
    checkOutput("idle_phase2", {63'h0, phase}, 64'h0);
    applyStimulus(1'b1, 4'hF, 32'h07070707, 1'b0);
    checkOutput("idle_phase3", {63'h0, phase}, 64'h1);
    expectWord(8'hFF, 64'h0707070707070707);
    applyStimulus(1'b1, 4'hF, 32'h07070707, 1'b0);
    checkOutput("idle_phase4", {63'h0, phase}, 64'h0);
    idleCycle();

    // Packing order with strobe timing.
    applyStimulus(1'b1, 4'h0, 32'h33221100, 1'b0);
    expectWord(8'h00, 64'h7766554433221100);
    applyStimulus(1'b1, 4'h0, 32'h77665544, 1'b0);
    checkOutput("pack_strobe", {63'h0, xgmii_out.ena}, 64'h1);
    idleCycle();
    checkOutput("pack_strobe_off", {63'h0, xgmii_out.ena}, 64'h0);
    checkOutput("pack_hold_data", xgmii_out.data, 64'h7766554433221100);

    // Gapped input: phase stays HIGH with no strobe across the gap.
    applyStimulus(1'b1, 4'h0, 32'h33221100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput("gap_phase", {63'h0, phase}, 64'h1);
    end
    expectWord(8'h00, 64'h7766554433221100);
    applyStimulus(1'b1, 4'h0, 32'h77665544, 1'b0);
    checkOutput("gap_strobe", {63'h0, xgmii_out.ena}, 64'h1);
    idleCycle();

    // Start lanes: lane 0 legal, lane 2 illegal (single-cycle pulse).
    applyStimulus(1'b1, 4'h1, 32'h030201FB, 1'b0);
    checkOutput("start_lane0", {63'h0, lane_err}, 64'h0);
    expectWord(8'h41, 64'h03FB0100030201FB);
    applyStimulus(1'b1, 4'h4, 32'h03FB0100, 1'b0);
    checkOutput("start_lane2", {63'h0, lane_err}, 64'h1);
    idleCycle();
    checkOutput("start_pulse_end", {63'h0, lane_err}, 64'h0);

    // Start byte value without ctrl, and multiple illegal Starts in one beat.
    applyStimulus(1'b1, 4'h0, 32'hFBFBFBFB, 1'b0);
    checkOutput("start_data_only", {63'h0, lane_err}, 64'h0);
    expectWord(8'hE0, 64'hFBFBFB00FBFBFBFB);
    applyStimulus(1'b1, 4'hE, 32'hFBFBFB00, 1'b0);
    checkOutput("start_multi", {63'h0, lane_err}, 64'h1);
    idleCycle();
    checkOutput("start_multi_end", {63'h0, lane_err}, 64'h0);

    // Resync with a stand-alone sync_clr: A is dropped.
    applyStimulus(1'b1, 4'h0, 32'hAAAAAAAA, 1'b0);
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
    checkOutput("resync_phase", {63'h0, phase}, 64'h0);
    applyStimulus(1'b1, 4'h0, 32'hCCCCCCCC, 1'b0);
    expectWord(8'h00, 64'hDDDDDDDDCCCCCCCC);
    applyStimulus(1'b1, 4'h0, 32'hDDDDDDDD, 1'b0);
    idleCycle();

    // Resync asserted together with C while HIGH.
    applyStimulus(1'b1, 4'h0, 32'hAAAAAAAA, 1'b0);
    applyStimulus(1'b1, 4'h0, 32'hCCCCCCCC, 1'b1);
    checkOutput("resync_with_c_phase", {63'h0, phase}, 64'h1);
    checkOutput("resync_with_c_ena", {63'h0, xgmii_out.ena}, 64'h0);
    expectWord(8'h00, 64'hDDDDDDDDCCCCCCCC);
    applyStimulus(1'b1, 4'h0, 32'hDDDDDDDD, 1'b0);
    idleCycle();

    // Reset mid-word: outputs back to idle values, held half discarded.
    applyStimulus(1'b1, 4'h0, 32'hAAAAAAAA, 1'b0);
    checkOutput("midreset_pre_phase", {63'h0, phase}, 64'h1);
    rst_n = 1'b0;
    idleCycle();
    checkOutput("midreset_phase", {63'h0, phase},          64'h0);
    checkOutput("midreset_ctrl",  {56'h0, xgmii_out.ctrl}, 64'hFF);
    checkOutput("midreset_data",  xgmii_out.data,          64'h0707070707070707);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h3, 32'h1111FBFB, 1'b0);
    expectWord(8'h03, 64'h222222221111FBFB);
    applyStimulus(1'b1, 4'h0, 32'h22222222, 1'b0);
    checkOutput("midreset_strobe", {63'h0, xgmii_out.ena}, 64'h1);
    idleCycle();
    idleCycle();

    checkOutput("queue_drained", 64'(expQ.size()), 64'h0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
